// File: rtl/fifo_ms_pkg.sv
// Shared types, constants and helpers for the multi-stream FIFO.
package fifo_ms_pkg;

   typedef enum logic {
      ARB_EXT = 1'b0,
      ARB_RR  = 1'b1
   } arb_mode_t;

   localparam int DROP_CNT_W = 16;

   // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_ms_flow.sv
// One flow: circular buffer with explicit pointer wrap (any DEPTH >= 2),
// occupancy count and full / almost-full / empty status.
module fifo_ms_flow
   import fifo_ms_pkg::*;
#(
   parameter int W        = 10,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3,
   parameter int CW       = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          almost_full_o,
   output logic          empty_o
);

   localparam int PW = clog2_min1(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // A pop needs data; a push needs room, which a same-cycle pop provides.
   always_comb begin
      full_o        = (count_q == CW'(DEPTH));
      empty_o       = (count_q == '0);
      almost_full_o = (count_q >= CW'(AF_LEVEL));
      do_pop        = pop_i && !empty_o;
      do_push       = push_i && (!full_o || do_pop);
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   // Pointer and count state; reset discards contents by zeroing both.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; no reset needed since the pointers gate every read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fifo_ms_rr.sv
// Multi-stream FIFO top: tag demux on the write side, one-hot or
// round-robin pop selection on the read side, registered dout and
// drop / underflow accounting.
//
// Strobe semantics: write and read/read_any are single-cycle requests with
// no back-pressure. A write is accepted iff its tag names a flow that is not
// full (or is popped the same cycle); otherwise it is counted in drop_cnt.
// A pop is performed iff the selected flow is non-empty; otherwise it only
// sets underflow. dout_valid pulses the cycle after an accepted pop.
module fifo_ms_rr
   import fifo_ms_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int FLUX       = 2,
   parameter int TAG_WIDTH  = clog2_min1(FLUX),
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int ARB_MODE   = 0,
   localparam int W         = TAG_WIDTH + DATA_WIDTH,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write,
   input  logic [W-1:0]          din,
   output logic [FLUX-1:0]       full,
   output logic [FLUX-1:0]       almost_full,
   input  logic [FLUX-1:0]       read,
   input  logic                  read_any,
   output logic [W-1:0]          dout,
   output logic                  dout_valid,
   output logic [FLUX-1:0]       empty,
   output logic [FLUX*CW-1:0]    count,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  underflow
);

   localparam int  SW     = clog2_min1(FLUX);
   localparam bit  USE_RR = (ARB_MODE == int'(ARB_RR));

   logic [TAG_WIDTH-1:0]  tag;
   logic                  tag_ok;
   logic [FLUX-1:0]       push, pop;
   logic [W-1:0]          head [FLUX];
   logic [SW-1:0]         sel;
   logic                  pop_req, found, multi, pop_hit, bad_pop, drop;
   logic [SW-1:0]         rr_q;
   logic [W-1:0]          dout_q;
   logic                  dout_valid_q, underflow_q;
   logic [DROP_CNT_W-1:0] drop_q;

   // Pop selection: lowest set read bit, or first non-empty flow after rr_q.
   always_comb begin
      pop_req = 1'b0;
      found   = 1'b0;
      multi   = 1'b0;
      sel     = '0;
      if (USE_RR) begin
         pop_req = read_any;
         for (int k = 1; k <= FLUX; k++) begin
            if (!found && !empty[SW'((int'(rr_q) + k) % FLUX)]) begin
               found = 1'b1;
               sel   = SW'((int'(rr_q) + k) % FLUX);
            end
         end
      end else begin
         pop_req = |read;
         multi   = (read & (read - FLUX'(1))) != '0;
         for (int i = FLUX - 1; i >= 0; i--) begin
            if (read[i]) sel = SW'(i);
         end
         found = !empty[sel];
      end
      pop_hit = pop_req && found;
      bad_pop = pop_req && (!found || multi);
      pop     = '0;
      if (pop_hit) pop[sel] = 1'b1;
   end

   // Tag demux; anything not pushed somewhere is a dropped write.
   always_comb begin
      tag    = din[W-1:DATA_WIDTH];
      tag_ok = (int'(tag) < FLUX);
      push   = '0;
      for (int i = 0; i < FLUX; i++) begin
         push[i] = write && tag_ok && (tag == TAG_WIDTH'(i)) && (!full[i] || pop[i]);
      end
      drop = write && (push == '0);
   end

   genvar g;
   generate
      for (g = 0; g < FLUX; g++) begin : g_flow
         fifo_ms_flow #(
            .W        (W),
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL),
            .CW       (CW)
         ) u_flow (
            .clk_i         (clk),
            .rst_ni        (rst),
            .push_i        (push[g]),
            .pop_i         (pop[g]),
            .din_i         (din),
            .head_o        (head[g]),
            .count_o       (count[g*CW +: CW]),
            .full_o        (full[g]),
            .almost_full_o (almost_full[g]),
            .empty_o       (empty[g])
         );
      end
   endgenerate

   // Read-side registers, arbiter pointer and error accounting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         drop_q       <= '0;
         underflow_q  <= 1'b0;
         rr_q         <= SW'(FLUX - 1);
      end else begin
         dout_valid_q <= pop_hit;
         if (pop_hit) dout_q <= head[sel];
         if (pop_hit && USE_RR) rr_q <= sel;
         if (bad_pop) underflow_q <= 1'b1;
         if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign drop_cnt   = drop_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ms_rr.sv
// Directed bench: a table of per-cycle vectors for the one-hot read build,
// plus hand-written sequences for round-robin and asynchronous reset.
module tb_fifo_ms_rr;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int FX = 4;
  localparam int W  = 10;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // One-hot read build
  logic          e_write, e_read_any;
  logic [W-1:0]  e_din, e_dout;
  logic [FX-1:0] e_read, e_full, e_af, e_empty;
  logic          e_dv, e_uf;
  logic [FX*CW-1:0] e_count;
  logic [15:0]   e_drop;

  // Round-robin build
  logic          r_write, r_read_any;
  logic [W-1:0]  r_din, r_dout;
  logic [FX-1:0] r_read, r_full, r_af, r_empty;
  logic          r_dv, r_uf;
  logic [FX*CW-1:0] r_count;
  logic [15:0]   r_drop;

  fifo_ms_rr #(.DATA_WIDTH(DW), .DEPTH(DP), .FLUX(FX), .ARB_MODE(0)) u_ext (
    .clk(clk), .rst(rst), .write(e_write), .din(e_din), .full(e_full),
    .almost_full(e_af), .read(e_read), .read_any(e_read_any), .dout(e_dout),
    .dout_valid(e_dv), .empty(e_empty), .count(e_count), .drop_cnt(e_drop),
    .underflow(e_uf)
  );

  fifo_ms_rr #(.DATA_WIDTH(DW), .DEPTH(DP), .FLUX(FX), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .write(r_write), .din(r_din), .full(r_full),
    .almost_full(r_af), .read(r_read), .read_any(r_read_any), .dout(r_dout),
    .dout_valid(r_dv), .empty(r_empty), .count(r_count), .drop_cnt(r_drop),
    .underflow(r_uf)
  );

  typedef struct {
    logic          wr;
    logic [W-1:0]  din;
    logic [FX-1:0] rd;
    logic [FX-1:0] empty;
    logic [FX-1:0] full;
    logic [FX-1:0] af;
    logic [11:0]   cnt;
    logic [W-1:0]  dout;
    logic          dv;
    logic [15:0]   drop;
    logic          uf;
  } vec_t;

  vec_t vt[28];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic wr, input logic [W-1:0] din, input logic [3:0] rd,
                              input logic [3:0] em, input logic [3:0] fu, input logic [3:0] af,
                              input logic [11:0] cnt, input logic [W-1:0] dout, input logic dv,
                              input logic [15:0] drop, input logic uf);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.empty = em; v.full = fu; v.af = af;
    v.cnt = cnt; v.dout = dout; v.dv = dv; v.drop = drop; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    e_write = 1'b0; e_din = '0; e_read = '0; e_read_any = 1'b0;
    r_write = 1'b0; r_din = '0; r_read = '0; r_read_any = 1'b0;
  endtask

  task automatic r_push(input logic [W-1:0] w);
    r_write = 1'b1; r_din = w;
    cyc();
    r_write = 1'b0; r_din = '0;
  endtask

  task automatic r_pop_chk(input string name, input logic [W-1:0] exp_dout,
                           input logic exp_dv, input logic exp_uf);
    r_read_any = 1'b1;
    cyc();
    r_read_any = 1'b0;
    chk({name, ".dout"}, 32'(r_dout), 32'(exp_dout));
    chk({name, ".dv"}, 32'(r_dv), 32'(exp_dv));
    chk({name, ".uf"}, 32'(r_uf), 32'(exp_uf));
  endtask

  initial begin
    idle_inputs();

    // Flow 2: fill, overflow, drain. Flow 0: fill, pop+write at full, drain.
    // Then multi-bit read, empty pop, and empty pop with same-cycle write.
    vt[0]  = mk(1, 10'h201, 4'b0000, 4'b1011, 4'b0000, 4'b0000,  64, 10'h000, 0, 0, 0);
    vt[1]  = mk(1, 10'h202, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 128, 10'h000, 0, 0, 0);
    vt[2]  = mk(1, 10'h203, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 192, 10'h000, 0, 0, 0);
    vt[3]  = mk(1, 10'h204, 4'b0000, 4'b1011, 4'b0100, 4'b0100, 256, 10'h000, 0, 0, 0);
    vt[4]  = mk(1, 10'h205, 4'b0000, 4'b1011, 4'b0100, 4'b0100, 256, 10'h000, 0, 1, 0);
    vt[5]  = mk(0, 10'h000, 4'b0100, 4'b1011, 4'b0000, 4'b0100, 192, 10'h201, 1, 1, 0);
    vt[6]  = mk(0, 10'h000, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 128, 10'h202, 1, 1, 0);
    vt[7]  = mk(0, 10'h000, 4'b0100, 4'b1011, 4'b0000, 4'b0000,  64, 10'h203, 1, 1, 0);
    vt[8]  = mk(0, 10'h000, 4'b0100, 4'b1111, 4'b0000, 4'b0000,   0, 10'h204, 1, 1, 0);
    vt[9]  = mk(0, 10'h000, 4'b0000, 4'b1111, 4'b0000, 4'b0000,   0, 10'h204, 0, 1, 0);
    vt[10] = mk(1, 10'h001, 4'b0000, 4'b1110, 4'b0000, 4'b0000,   1, 10'h204, 0, 1, 0);
    vt[11] = mk(1, 10'h002, 4'b0000, 4'b1110, 4'b0000, 4'b0000,   2, 10'h204, 0, 1, 0);
    vt[12] = mk(1, 10'h003, 4'b0000, 4'b1110, 4'b0000, 4'b0001,   3, 10'h204, 0, 1, 0);
    vt[13] = mk(1, 10'h004, 4'b0000, 4'b1110, 4'b0001, 4'b0001,   4, 10'h204, 0, 1, 0);
    vt[14] = mk(1, 10'h009, 4'b0001, 4'b1110, 4'b0001, 4'b0001,   4, 10'h001, 1, 1, 0);
    vt[15] = mk(0, 10'h000, 4'b0001, 4'b1110, 4'b0000, 4'b0001,   3, 10'h002, 1, 1, 0);
    vt[16] = mk(0, 10'h000, 4'b0001, 4'b1110, 4'b0000, 4'b0000,   2, 10'h003, 1, 1, 0);
    vt[17] = mk(0, 10'h000, 4'b0001, 4'b1110, 4'b0000, 4'b0000,   1, 10'h004, 1, 1, 0);
    vt[18] = mk(0, 10'h000, 4'b0001, 4'b1111, 4'b0000, 4'b0000,   0, 10'h009, 1, 1, 0);
    vt[19] = mk(1, 10'h307, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 512, 10'h009, 0, 1, 0);
    vt[20] = mk(1, 10'h108, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 520, 10'h009, 0, 1, 0);
    vt[21] = mk(1, 10'h006, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 521, 10'h009, 0, 1, 0);
    vt[22] = mk(0, 10'h000, 4'b0011, 4'b0101, 4'b0000, 4'b0000, 520, 10'h006, 1, 1, 1);
    vt[23] = mk(0, 10'h000, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 520, 10'h006, 0, 1, 1);
    vt[24] = mk(0, 10'h000, 4'b0010, 4'b0111, 4'b0000, 4'b0000, 512, 10'h108, 1, 1, 1);
    vt[25] = mk(1, 10'h255, 4'b0100, 4'b0011, 4'b0000, 4'b0000, 576, 10'h108, 0, 1, 1);
    vt[26] = mk(0, 10'h000, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 512, 10'h255, 1, 1, 1);
    vt[27] = mk(0, 10'h000, 4'b1000, 4'b1111, 4'b0000, 4'b0000,   0, 10'h307, 1, 1, 1);

    // Reset held for two cycles.
    cyc();
    cyc();
    chk("rst.empty", 32'(e_empty), 32'hF);
    chk("rst.full",  32'(e_full),  32'h0);
    chk("rst.af",    32'(e_af),    32'h0);
    chk("rst.count", 32'(e_count), 32'h0);
    chk("rst.drop",  32'(e_drop),  32'h0);
    chk("rst.dout",  32'(e_dout),  32'h0);
    chk("rst.dv",    32'(e_dv),    32'h0);
    chk("rst.uf",    32'(e_uf),    32'h0);
    chk("rst.rr_empty", 32'(r_empty), 32'hF);
    chk("rst.rr_dout",  32'(r_dout),  32'h0);
    #2 rst = 1'b1;

    // Table-driven vectors against the one-hot read build.
    for (int i = 0; i < 28; i++) begin
      e_write = vt[i].wr;
      e_din   = vt[i].din;
      e_read  = vt[i].rd;
      cyc();
      chk($sformatf("v%0d.empty", i), 32'(e_empty), 32'(vt[i].empty));
      chk($sformatf("v%0d.full", i),  32'(e_full),  32'(vt[i].full));
      chk($sformatf("v%0d.af", i),    32'(e_af),    32'(vt[i].af));
      chk($sformatf("v%0d.count", i), 32'(e_count), 32'(vt[i].cnt));
      chk($sformatf("v%0d.dout", i),  32'(e_dout),  32'(vt[i].dout));
      chk($sformatf("v%0d.dv", i),    32'(e_dv),    32'(vt[i].dv));
      chk($sformatf("v%0d.drop", i),  32'(e_drop),  32'(vt[i].drop));
      chk($sformatf("v%0d.uf", i),    32'(e_uf),    32'(vt[i].uf));
    end
    idle_inputs();

    // Round-robin: flows 0,1,3 loaded, served in order, then all-empty pop.
    r_push(10'h00A);
    r_push(10'h10B);
    r_push(10'h30D);
    chk("rr.empty_loaded", 32'(r_empty), 32'b0100);
    r_pop_chk("rr.p0", 10'h00A, 1'b1, 1'b0);
    r_pop_chk("rr.p1", 10'h10B, 1'b1, 1'b0);
    r_pop_chk("rr.p2", 10'h30D, 1'b1, 1'b0);
    r_pop_chk("rr.p3", 10'h30D, 1'b0, 1'b1);
    chk("rr.empty_drained", 32'(r_empty), 32'hF);
    // Pointer sits on flow 3: scan wraps to flow 0 before flow 1.
    r_push(10'h121);
    r_push(10'h020);
    r_pop_chk("rr.wrap0", 10'h020, 1'b1, 1'b1);
    r_pop_chk("rr.wrap1", 10'h121, 1'b1, 1'b1);
    chk("rr.drop", 32'(r_drop), 32'h0);

    // Asynchronous reset mid-operation on partly filled flows.
    e_write = 1'b1; e_din = 10'h1AA;
    cyc();
    e_din = 10'h1BB;
    cyc();
    e_write = 1'b0; e_din = '0;
    chk("ar.pre_count", 32'(e_count), 32'd16);
    #3 rst = 1'b0;
    #1;
    chk("ar.empty", 32'(e_empty), 32'hF);
    chk("ar.count", 32'(e_count), 32'h0);
    chk("ar.full",  32'(e_full),  32'h0);
    chk("ar.af",    32'(e_af),    32'h0);
    chk("ar.dout",  32'(e_dout),  32'h0);
    chk("ar.dv",    32'(e_dv),    32'h0);
    chk("ar.drop",  32'(e_drop),  32'h0);
    chk("ar.uf",    32'(e_uf),    32'h0);
    chk("ar.rr_uf", 32'(r_uf),    32'h0);
    chk("ar.rr_dout", 32'(r_dout), 32'h0);
    #2 rst = 1'b1;
    e_write = 1'b1; e_din = 10'h1CC;
    cyc();
    e_write = 1'b0; e_din = '0;
    chk("ar.post_count", 32'(e_count), 32'd8);
    e_read = 4'b0010;
    cyc();
    e_read = '0;
    chk("ar.post_dout", 32'(e_dout), 32'h1CC);
    chk("ar.post_dv",   32'(e_dv),   32'h1);
    chk("ar.post_empty", 32'(e_empty), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
